// File: rtl/scan_arb_pkg.sv
// scan_arb_pkg: shared state/owner encodings and default thresholds
// for the scanner flush arbiter.
package scan_arb_pkg;
    typedef enum logic [1:0] {IDLE, XFER_A, XFER_B, COOLDOWN} arb_state_t;
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;
    localparam int DEF_FULL_LVL = 100;
    localparam int DEF_TIMEOUT = 200;
endpackage

// File: rtl/xfer_timer.sv
// xfer_timer: saturating grant-hold timer; expire flags the last allowed
// cycle of a grant (count == TIMEOUT - 1).
module xfer_timer
    import scan_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign expire = cnt == TW'(TIMEOUT - 1);
endmodule

// File: rtl/scan_flush_arbiter.sv
// scan_flush_arbiter: grants the shared flush link to one of two scanners,
// holds it until the buffer drains or times out, with urgency and round-robin.
module scan_flush_arbiter
    import scan_arb_pkg::*;
#(
    parameter int MEM_W    = 8,
    parameter int FULL_LVL = DEF_FULL_LVL,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdy_flush_a,
    input  logic             rdy_flush_b,
    input  logic [MEM_W-1:0] mem_used_a,
    input  logic [MEM_W-1:0] mem_used_b,
    input  logic             link_busy,
    output logic             flush_a,
    output logic             flush_b,
    output logic             xfer_active,
    output logic             xfer_owner,
    output logic             xfer_done,
    output logic             xfer_err,
    output logic [CNT_W-1:0] xfer_count
);
    arb_state_t state, next;
    owner_t     last_owner;
    logic       urg_a, urg_b, pick_b, in_xfer, done_c, err_c, expire;

    xfer_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_xfer),
        .enable (in_xfer),
        .expire (expire)
    );

    always_comb begin
        urg_a   = mem_used_a >= MEM_W'(FULL_LVL);
        urg_b   = mem_used_b >= MEM_W'(FULL_LVL);
        // a lone urgent requester wins, otherwise whoever was not served last
        pick_b  = (urg_a != urg_b) ? urg_b : (last_owner == OWN_A);
        in_xfer = (state == XFER_A) || (state == XFER_B);
        done_c  = ((state == XFER_A) && mem_used_a == '0) || ((state == XFER_B) && mem_used_b == '0);
        err_c   = in_xfer && !done_c && expire;
        next    = state;
        unique case (state)
            IDLE:
                if (!link_busy && (rdy_flush_a || rdy_flush_b))
                    next = (rdy_flush_b && (!rdy_flush_a || pick_b)) ? XFER_B : XFER_A;
            XFER_A, XFER_B:
                if (done_c || err_c) next = COOLDOWN;
            default:
                next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_owner  <= OWN_B;
            flush_a     <= 1'b0;
            flush_b     <= 1'b0;
            xfer_active <= 1'b0;
            xfer_owner  <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_err    <= 1'b0;
            xfer_count  <= '0;
        end else begin
            state       <= next;
            last_owner  <= (done_c || err_c) ? ((state == XFER_B) ? OWN_B : OWN_A) : last_owner;
            flush_a     <= next == XFER_A;
            flush_b     <= next == XFER_B;
            xfer_active <= (next == XFER_A) || (next == XFER_B);
            xfer_owner  <= (next == XFER_B) ? 1'b1 : (next == XFER_A) ? 1'b0 : xfer_owner;
            xfer_done   <= done_c;
            xfer_err    <= err_c;
            xfer_count  <= xfer_count + CNT_W'(done_c);
        end
    end
endmodule

// File: tb/tb_scan_flush_arbiter.sv
// tb_scan_flush_arbiter: directed scenarios with a simple scanner model;
// expected transfer outcomes are queued and checked by an independent monitor.
module tb_scan_flush_arbiter;
    logic       clk, reset, rdy_a, rdy_b, link_busy, drain_a, drain_b;
    logic [7:0] mem_a, mem_b;
    logic       flush_a, flush_b, xfer_active, xfer_owner, xfer_done, xfer_err;
    logic [7:0] xfer_count;

    typedef struct packed {
        logic        err;
        logic        own;
        logic [7:0]  cnt;
        logic [15:0] len;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   mon_len = 0;
    logic mon_own = 0, mon_both = 0;
    logic [7:0] exp_cnt;

    scan_flush_arbiter dut (
        .clk(clk), .reset(reset),
        .rdy_flush_a(rdy_a), .rdy_flush_b(rdy_b),
        .mem_used_a(mem_a), .mem_used_b(mem_b),
        .link_busy(link_busy),
        .flush_a(flush_a), .flush_b(flush_b),
        .xfer_active(xfer_active), .xfer_owner(xfer_owner),
        .xfer_done(xfer_done), .xfer_err(xfer_err),
        .xfer_count(xfer_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void expect_end(input logic err, input logic own, input logic [7:0] cnt, input int len);
        q.push_back('{err, own, cnt, 16'(len)});
    endfunction

    // monitor: measures each grant and scores it when done/err pulses
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_len = 0;
                mon_both = 0;
            end else begin
                if (flush_a || flush_b) begin
                    mon_len++;
                    mon_own = flush_b;
                    if (flush_a && flush_b) mon_both = 1;
                end
                if (xfer_done || xfer_err) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_end done=%0b err=%0b expected=none", xfer_done, xfer_err);
                    end else begin
                        e = q.pop_front();
                        chk("end_is_err", {31'd0, xfer_err}, {31'd0, e.err});
                        chk("end_not_done", {31'd0, xfer_done}, {31'd0, ~e.err});
                        chk("end_owner", {31'd0, mon_own}, {31'd0, e.own});
                        chk("end_count", {24'd0, xfer_count}, {24'd0, e.cnt});
                        chk("flush_len", mon_len, {16'd0, e.len});
                        chk("both_flush", {31'd0, mon_both}, 32'd0);
                    end
                    mon_len = 0;
                    mon_both = 0;
                end
            end
        end
    end

    // scanner model: drops rdy once flushing, drains one entry per cycle
    task automatic tick();
        @(negedge clk);
        if (flush_a) begin
            rdy_a = 0;
            if (drain_a && mem_a != 0) mem_a = mem_a - 1;
        end
        if (flush_b) begin
            rdy_b = 0;
            if (drain_b && mem_b != 0) mem_b = mem_b - 1;
        end
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(xfer_done || xfer_err) && n < budget);
        if (!(xfer_done || xfer_err)) begin
            checks++;
            errors++;
            $display("FAIL wait_end no done/err within %0d cycles", budget);
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 0;
        rdy_a = 0;
        rdy_b = 0;
        tick();
        tick();
        reset = 1;
        tick();
    endtask

    initial begin
        reset = 0; rdy_a = 0; rdy_b = 0; link_busy = 0;
        mem_a = 0; mem_b = 0; drain_a = 1; drain_b = 1;
        tick();
        chk("reset_outputs", {flush_a, flush_b, xfer_active, xfer_owner, xfer_done, xfer_err, xfer_count}, 0);
        reset = 1;
        tick();

        // single requester A draining 85 entries
        mem_a = 85; rdy_a = 1;
        expect_end(0, 0, 1, 85);
        tick();
        chk("grant_a_latency", {flush_a, flush_b, xfer_active, xfer_owner}, 4'b1010);
        wait_end(300);
        chk("after_a_idle", {flush_a, flush_b, xfer_active, xfer_done, xfer_err}, 0);
        chk("count_one", xfer_count, 1);

        // tie from reset: A, then B, then A again
        do_reset();
        mem_a = 85; mem_b = 85; rdy_a = 1; rdy_b = 1;
        expect_end(0, 0, 1, 85);
        expect_end(0, 1, 2, 85);
        tick();
        chk("tie_first_a", {flush_a, flush_b}, 2'b10);
        wait_end(300);
        wait_end(300);
        mem_a = 85; mem_b = 85; rdy_a = 1; rdy_b = 1;
        expect_end(0, 0, 3, 85);
        expect_end(0, 1, 4, 85);
        tick();
        chk("tie_alternate_a", {flush_a, flush_b}, 2'b10);
        wait_end(300);
        wait_end(300);

        // urgent B beats round-robin even though B was last owner
        mem_a = 85; mem_b = 100; rdy_a = 1; rdy_b = 1;
        expect_end(0, 1, 5, 100);
        expect_end(0, 0, 6, 85);
        tick();
        chk("urgent_b", {flush_a, flush_b}, 2'b01);
        wait_end(300);
        wait_end(300);

        // A never drains: aborted after TIMEOUT cycles, count unchanged
        drain_a = 0; mem_a = 50; rdy_a = 1;
        expect_end(1, 0, 6, 200);
        wait_end(300);
        chk("count_after_err", xfer_count, 6);
        drain_a = 1; mem_a = 50; mem_b = 10; rdy_a = 1; rdy_b = 1;
        expect_end(0, 1, 7, 10);
        expect_end(0, 0, 8, 50);
        tick();
        chk("b_after_timeout", {flush_a, flush_b}, 2'b01);
        wait_end(300);
        wait_end(300);

        // link_busy blocks new grants but does not preempt
        link_busy = 1; mem_b = 40; rdy_b = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busy_no_grant", {flush_a, flush_b, xfer_active}, 0);
        end
        link_busy = 0;
        expect_end(0, 1, 9, 40);
        tick();
        chk("grant_after_busy", {flush_b, xfer_active, xfer_owner}, 3'b111);
        tick();
        link_busy = 1;
        wait_end(300);
        link_busy = 0;

        // asynchronous reset mid-transfer
        mem_b = 60; rdy_b = 1;
        tick();
        tick();
        tick();
        chk("b_before_reset", flush_b, 1);
        #2 reset = 0;
        #1 chk("async_reset_outputs", {flush_a, flush_b, xfer_active, xfer_owner, xfer_done, xfer_err, xfer_count}, 0);
        tick();
        tick();
        reset = 1;
        tick();
        mem_a = 85; mem_b = 85; rdy_a = 1; rdy_b = 1;
        expect_end(0, 0, 1, 85);
        expect_end(0, 1, 2, 85);
        tick();
        chk("post_reset_tie_a", {flush_a, flush_b}, 2'b10);
        wait_end(300);
        wait_end(300);

        // empty buffer on first cycle, then counter wrap over 256 transfers
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            mem_a = (i == 0) ? 8'd0 : 8'd1;
            rdy_a = 1;
            exp_cnt = exp_cnt + 1;
            expect_end(0, 0, exp_cnt, 1);
            wait_end(20);
        end
        chk("count_wrapped", xfer_count, 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_flush_arbiter.md
Name: scan_flush_arbiter

Overview:
- Arbitrates the single shared transfer (flush) link between scanner A and scanner B.
- Watches each scanner's rdy_flush and mem_used, grants the flush to exactly one scanner at a time and holds it until that scanner's buffer drains to 0.
- Enforces a drain timeout, round-robin fairness and urgency override, and counts completed transfers.
- Sits above the two scanner instances; drives their flush inputs.

Parameters:
- MEM_W, 8, width of mem_used inputs.
- FULL_LVL, 100, mem_used value at or above which a requester is urgent.
- TIMEOUT, 200, maximum cycles a grant may be held before abort.
- CNT_W, 8, width of xfer_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- rdy_flush_a  in  1  scanner A ready to transfer.
- rdy_flush_b  in  1  scanner B ready to transfer.
- mem_used_a  in  MEM_W  scanner A buffer fill.
- mem_used_b  in  MEM_W  scanner B buffer fill.
- link_busy  in  1  external link unavailable; no new grant while 1.
- flush_a  out  1  flush command to scanner A (level).
- flush_b  out  1  flush command to scanner B (level).
- xfer_active  out  1  a grant is held.
- xfer_owner  out  1  0 = A, 1 = B; valid while xfer_active.
- xfer_done  out  1  one-cycle pulse on successful drain.
- xfer_err  out  1  one-cycle pulse on timeout abort.
- xfer_count  out  CNT_W  successful transfers, wraps.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs 0; xfer_count = 0; timer = 0.
  - last_owner = B, so A wins the first tie.
  - Reset mid-transfer drops flush immediately; no done or err pulse is generated.
- All outputs are registered (Moore, from state and flags).
- FSM states: IDLE, XFER_A, XFER_B, COOLDOWN.
- IDLE:
  - If link_busy = 1, stay.
  - Else if exactly one rdy_flush is high, go to that scanner's XFER state.
  - If both are high, urgency decides: urgent means mem_used >= FULL_LVL. If exactly one scanner is urgent, it wins.
  - Otherwise (both or neither urgent), grant the scanner that is not last_owner.
  - Requests are sampled at edge N; flush_x, xfer_active and xfer_owner are high from edge N (one-cycle request-to-grant latency).
- XFER_x:
  - flush_x = 1; the other flush stays 0 (never both high).
  - timer increments each cycle from 0.
  - rdy_flush_x is ignored while granted; the scanner may drop it once it enters flushing.
  - Rising link_busy does not preempt the grant.
  - mem_used_x == 0 sampled at an edge: go to COOLDOWN with xfer_done = 1 for that cycle, xfer_count += 1 (wrapping to 0 after 2^CNT_W - 1), last_owner = x.
  - Otherwise, if timer == TIMEOUT - 1: go to COOLDOWN with xfer_err = 1, count unchanged, last_owner = x.
  - If both conditions hold on the same edge, done wins.
  - mem_used_x already 0 on the first XFER cycle gives a one-cycle flush and counts as done.
- COOLDOWN:
  - Lasts exactly one cycle; flush_a = flush_b = 0 and xfer_active = 0.
  - Then IDLE; timer is cleared.
  - Requests are not sampled here, so there is a minimum gap of one cycle between grants.
- Widths:
  - timer is $clog2(TIMEOUT) bits and saturates (never wraps).
  - The mem_used comparisons are unsigned at MEM_W bits.

Decomposition:
- Package scan_arb_pkg:
  - enum arb_state_t {IDLE, XFER_A, XFER_B, COOLDOWN}.
  - enum owner_t {OWN_A = 0, OWN_B = 1}.
  - Default FULL_LVL and TIMEOUT constants.
- Sub-module xfer_timer (clear, enable, expire output at TIMEOUT - 1, saturating).
- Arbitration decision and FSM live in the top module.

Test Plan:
- Only rdy_flush_a rises; mem_used_a counts 85→0 over 85 cycles.
  - Expect flush_a high the cycle after the request and held 85 cycles.
  - Expect xfer_done one pulse, xfer_count = 1, then flush_a = 0 in COOLDOWN and IDLE one cycle later.
- Both rdy high from reset with mem_used_a = 85 and mem_used_b = 85.
  - Expect A granted first, then B after A drains.
  - On the next simultaneous request, expect A again (alternation).
- Both rdy high with mem_used_a = 85 and mem_used_b = 100.
  - Expect B granted despite last_owner = B.
- Grant A with mem_used_a stuck at 50 and TIMEOUT = 200.
  - Expect flush_a high exactly 200 cycles, xfer_err pulse, xfer_count unchanged.
  - Then B is served on the next request.
- link_busy = 1 while rdy_flush_b = 1: no grant.
  - Release link_busy: grant B next cycle.
  - Assert link_busy mid-transfer: grant is retained.
- Assert reset low mid-XFER_B.
  - Expect flush_b = 0 and all outputs 0 without waiting for a clock.
  - After release, expect IDLE and A winning the first tie.
- Run 256 successful transfers: expect xfer_count to wrap 255→0.
